// File: rtl/tmds_channel_decoder.sv
// TMDS lane decoder: finds word alignment from control-token runs, then decodes tokens and data symbols.
// Latency 1 cycle din_valid -> dout_valid; no backpressure, a word is consumed on every din_valid.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       dout_valid,
  output logic       locked,
  output logic [3:0] offset
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0]  LOCK_N   = 8'(LOCK_TOKENS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [9:0]  prev_word;
  logic [7:0]  run_cnt, run_nxt, run_inc;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  offset_nxt;

  // din[9] only ever reaches the symbol through prev_word since offset never exceeds 9
  logic [18:0] window;
  logic [9:0]  sym;
  logic        is_token;
  logic [1:0]  tok_cd;
  logic [7:0]  q, dec;
  logic        qualify, timeout;

  assign window = {din[8:0], prev_word};

  always_comb begin
    sym = window[9:0];
    case (offset)
      4'd0:    sym = window[9:0];
      4'd1:    sym = window[10:1];
      4'd2:    sym = window[11:2];
      4'd3:    sym = window[12:3];
      4'd4:    sym = window[13:4];
      4'd5:    sym = window[14:5];
      4'd6:    sym = window[15:6];
      4'd7:    sym = window[16:7];
      4'd8:    sym = window[17:8];
      4'd9:    sym = window[18:9];
      default: sym = window[9:0];
    endcase
  end

  always_comb begin
    is_token = 1'b1;
    tok_cd   = 2'b00;
    case (sym)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // bit 9 flags DC-balance inversion, bit 8 selects XOR vs XNOR chaining
  always_comb begin
    q      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  assign run_inc = !is_token          ? 8'd0 :
                   (run_cnt == LOCK_N) ? run_cnt : run_cnt + 8'd1;
  assign qualify = is_token && (run_inc == LOCK_N);
  assign timeout = (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      offset    <= 4'd0;
      run_cnt   <= 8'd0;
      timer     <= 16'd0;
      prev_word <= 10'd0;
    end else begin
      state   <= state_nxt;
      offset  <= offset_nxt;
      run_cnt <= run_nxt;
      timer   <= timer_nxt;
      if (din_valid) prev_word <= din;
    end
  end

  // lock qualification is tested before timeout so it wins when both land on one symbol
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run_cnt;
    timer_nxt  = timer;
    if (din_valid) begin
      run_nxt   = run_inc;
      timer_nxt = timer + 16'd1;
      case (state)
        SEARCH: begin
          if (qualify) begin
            state_nxt = LOCKED;
            timer_nxt = 16'd0;
          end else if (timeout) begin
            offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            run_nxt    = 8'd0;
            timer_nxt  = 16'd0;
          end
        end
        LOCKED: begin
          if (qualify) begin
            timer_nxt = 16'd0;
          end else if (timeout) begin
            state_nxt = SEARCH;
            run_nxt   = 8'd0;
            timer_nxt = 16'd0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vd         <= 8'h00;
      cd         <= 2'b00;
      vde        <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        if (state != LOCKED) begin
          vd  <= 8'h00;
          cd  <= 2'b00;
          vde <= 1'b0;
        end else if (is_token) begin
          vd  <= 8'h00;
          cd  <= tok_cd;
          vde <= 1'b0;
        end else begin
          vd  <= dec;
          vde <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboarded bench for tmds_channel_decoder: directed token/data streams at several bit shifts.
module tb_tmds_channel_decoder;

  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef struct packed {
    logic       care;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = 10'd0;
  logic       din_valid = 1'b0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde, dout_valid, locked;
  logic [3:0] offset;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t pend;
  logic [9:0] last_s;

  tmds_channel_decoder dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .vd(vd), .cd(cd), .vde(vde), .dout_valid(dout_valid),
    .locked(locked), .offset(offset)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic care, input logic [7:0] v, input logic [1:0] c, input logic e);
    exp_t r;
    r.care = care; r.vd = v; r.cd = c; r.vde = e;
    return r;
  endfunction

  // DVI-style 8b/10b data encoder; polarity bit chosen by the caller
  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    logic [7:0] qm;
    logic       use_xnor;
    use_xnor = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each word's output reflects the previously sent symbol, so the expectation lags one word.
  task automatic xmit(input logic [9:0] s, input int sh, input exp_t e);
    logic [19:0] cat;
    cat = {s, last_s} >> (10 - sh);
    @(negedge clk);
    din       = cat[9:0];
    din_valid = 1'b1;
    sb.push_back(pend);
    pend   = e;
    last_s = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(2);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = TOK_10;
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    pend      = mk(1'b1, 8'h00, 2'b00, 1'b0);
    last_s    = 10'd0;
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got unexpected output expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.care) begin
          n_cmp++;
          if ({vd, cd, vde} !== {e.vd, e.cd, e.vde}) begin
            n_err++;
            $display("FAIL sb_out: got vd=%h cd=%b vde=%b expected vd=%h cd=%b vde=%b at %0t",
                     vd, cd, vde, e.vd, e.cd, e.vde, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] vals [4];
    logic [9:0] s;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'hA5; vals[3] = 8'h3C;
    pend   = mk(1'b0, 8'h00, 2'b00, 1'b0);
    last_s = 10'd0;

    do_reset();
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_offset", 16'(offset), 16'd0);
    chk("rst_dout",   16'({vd, cd, vde, dout_valid}), 16'd0);

    // aligned lock on blue-lane vsync tokens, data both polarities, data-only timeout, relock
    for (int i = 0; i < 200; i++) begin
      xmit(TOK_10, 0, mk(1'b1, 8'h00, (i >= 16) ? 2'b10 : 2'b00, 1'b0));
      if (i == 16) chk("a_prelock", 16'(locked), 16'd0);
      if (i == 17) begin
        chk("a_lock", 16'(locked), 16'd1);
        chk("a_lock_off", 16'(offset), 16'd0);
      end
    end
    for (int j = 0; j < 1024; j++) begin
      b = (j < 8) ? vals[j/2] : 8'(j * 37);
      xmit(enc(b, (j < 8) ? j[0] : j[1]), 0, mk(1'b1, b, 2'b10, 1'b1));
    end
    for (int i = 1224; i < 1264; i++) begin
      xmit(TOK_01, 0, mk(1'b1, 8'h00, (i >= 1240) ? 2'b01 : 2'b00, 1'b0));
      if (i == 1224) chk("a_hold_lock", 16'(locked), 16'd1);
      if (i == 1225) begin
        chk("a_unlock", 16'(locked), 16'd0);
        chk("a_unlock_off", 16'(offset), 16'd0);
      end
      if (i == 1240) chk("a_prerelock", 16'(locked), 16'd0);
      if (i == 1241) chk("a_relock", 16'(locked), 16'd1);
    end
    idle(3);

    // din_valid alternating during lock acquisition
    do_reset();
    for (int i = 0; i < 20; i++) begin
      xmit(TOK_10, 0, mk(1'b1, 8'h00, (i >= 16) ? 2'b10 : 2'b00, 1'b0));
      chk("b_dv_low", 16'(dout_valid), 16'd0);
      idle(1);
      chk("b_dv_high", 16'(dout_valid), 16'd1);
      if (i == 15) chk("b_prelock", 16'(locked), 16'd0);
      if (i == 16) chk("b_lock", 16'(locked), 16'd1);
    end
    idle(3);

    // stream shifted by 7 with periodic blanking: offset walks 0..7, then locks
    do_reset();
    for (int i = 0; i < 7300; i++) begin
      s = ((i % 800) < 160) ? TOK_10 : enc(8'(i * 13), i[0]);
      xmit(s, 7, (i >= 7216) ? mk(1'b1, 8'h00, 2'b10, 1'b0) : mk(1'b1, 8'h00, 2'b00, 1'b0));
      if (i == 1023) chk("c_off_before_step", 16'(offset), 16'd0);
      if (i > 0 && (i % 1024) == 0 && i <= 7168) chk("c_off_step", 16'(offset), 16'(i / 1024));
      if (i == 7216) chk("c_prelock", 16'(locked), 16'd0);
      if (i == 7217) begin
        chk("c_lock", 16'(locked), 16'd1);
        chk("c_lock_off", 16'(offset), 16'd7);
      end
    end
    idle(3);

    // lock at offset 4, then reset mid-lock
    do_reset();
    for (int i = 0; i < 4120; i++) begin
      s = (i < 4100) ? enc(8'(i * 7), i[1]) : TOK_11;
      xmit(s, 4, (i >= 4116) ? mk(1'b1, 8'h00, 2'b11, 1'b0) : mk(1'b1, 8'h00, 2'b00, 1'b0));
      if (i == 4096) chk("d_off4", 16'(offset), 16'd4);
    end
    idle(2);
    chk("d_locked", 16'(locked), 16'd1);
    chk("d_off", 16'(offset), 16'd4);
    do_reset();
    chk("d_rst_locked", 16'(locked), 16'd0);
    chk("d_rst_off", 16'(offset), 16'd0);
    chk("d_rst_out", 16'({vd, cd, vde, dout_valid}), 16'd0);

    idle(3);
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
